// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache with 4-word blocks and a blocking miss FSM.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_controller #(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         read,
    input  logic [31:0]  address,
    input  logic         flush,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int unsigned TAG_BITS   = 32 - 4 - INDEX_BITS;
    localparam int unsigned NUM_BLOCKS = 1 << INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StMemRead, StUpdate} state_e;

    state_e                  state_q, state_d;
    logic [27:0]             miss_addr_q, miss_addr_d;
    logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]     tag_q  [NUM_BLOCKS];
    logic [127:0]            data_q [NUM_BLOCKS];

    logic [INDEX_BITS-1:0]   addr_idx;
    logic [TAG_BITS-1:0]     addr_tag;
    logic [1:0]              addr_word;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_BITS-1:0]     fill_tag;
    logic                    hit;
    logic                    fill_en;
    logic                    miss_start;
    logic                    unused_addr;

    assign addr_idx    = address[4 +: INDEX_BITS];
    assign addr_tag    = address[31 -: TAG_BITS];
    assign addr_word   = address[3:2];
    assign fill_idx    = miss_addr_q[INDEX_BITS-1:0];
    assign fill_tag    = miss_addr_q[27 -: TAG_BITS];
    assign unused_addr = ^address[1:0];

    assign hit         = read & valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
    assign instruction = data_q[addr_idx][{addr_word, 5'b0} +: 32];
    assign mem_address = miss_addr_q;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        busywait    = 1'b0;
        mem_read    = 1'b0;
        fill_en     = 1'b0;
        miss_start  = 1'b0;
        case (state_q)
            StIdle: begin
                if (read && !hit) begin
                    busywait    = 1'b1;
                    miss_start  = 1'b1;
                    miss_addr_d = address[31:4];
                    state_d     = StMemRead;
                end
            end
            StMemRead: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                busywait = 1'b1;
                fill_en  = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // An in-flight fill survives a flush: its data was fetched after the flush point.
        if (flush) begin
            valid_d = '0;
        end
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en && !rst) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_readdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == StIdle && hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (miss_start) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a fixed 3-cycle instruction memory model.
// Block words read as ({byte address} ^ 32'h5A5A_0000), so expected words are hand-derivable.
module tb_icache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         read;
    logic [31:0]  address;
    logic         flush;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int checks = 0;
    int errors = 0;
    int mem_cnt = 0;

    always #5 clk = ~clk;

    icache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .read         (read),
        .address      (address),
        .flush        (flush),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    // Memory: busy for the first two request cycles, data ready on the third.
    always @(posedge clk) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
    assign mem_busywait = mem_read && (mem_cnt != 2);
    always_comb begin
        mem_readdata = '0;
        for (int k = 0; k < 4; k++) begin
            mem_readdata[k*32 +: 32] = {mem_address, 2'(k), 2'b00} ^ 32'h5A5A_0000;
        end
    end

    task automatic do_reset();
        rst = 1'b1; read = 1'b0; flush = 1'b0; address = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, output int cycles, output logic [31:0] instr,
                         output logic [27:0] maddr, output logic saw_mem);
        @(posedge clk);
        #1 read = 1'b1; address = a;
        #1;
        cycles = 0; saw_mem = 1'b0; maddr = '0;
        while (busywait && cycles < 50) begin
            if (mem_read) begin saw_mem = 1'b1; maddr = mem_address; end
            @(posedge clk);
            #2 cycles++;
        end
        instr = instruction;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (busywait && cycles < 50) begin
            @(posedge clk);
            #2 cycles++;
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1 read = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %b want 0", busywait); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
        checks++; if (mem_address !== 28'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
        checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
        checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
    endtask

    task automatic test_cold_miss();
        int c; logic [31:0] ins; logic [27:0] ma; logic sm;
        fetch(32'h0000_0010, c, ins, ma, sm);
        checks++; if (c !== 5) begin errors++; $display("FAIL cold_busy_cycles: got %0d want 5", c); end
        checks++; if (sm !== 1'b1) begin errors++; $display("FAIL cold_mem_read: got %b want 1", sm); end
        checks++; if (ma !== 28'h000_0001) begin errors++; $display("FAIL cold_mem_address: got %h want 0000001", ma); end
        checks++; if (ins !== 32'h5A5A_0010) begin errors++; $display("FAIL cold_instr: got %h want 5a5a0010", ins); end
    endtask

    task automatic test_seq_hits();
        int c; logic [31:0] ins; logic [27:0] ma; logic sm;
        logic [31:0] addrs [3] = '{32'h14, 32'h18, 32'h1C};
        logic [31:0] words [3] = '{32'h5A5A_0014, 32'h5A5A_0018, 32'h5A5A_001C};
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i], c, ins, ma, sm);
            checks++; if (c !== 0) begin errors++; $display("FAIL seq_busy[%0d]: got %0d want 0", i, c); end
            checks++; if (sm !== 1'b0) begin errors++; $display("FAIL seq_mem_read[%0d]: got %b want 0", i, sm); end
            checks++; if (ins !== words[i]) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", i, ins, words[i]); end
        end
    endtask

    task automatic test_conflict();
        int c; logic [31:0] ins; logic [27:0] ma; logic sm;
        fetch(32'h0000_0090, c, ins, ma, sm);
        checks++; if (c !== 5) begin errors++; $display("FAIL conflict_busy_90: got %0d want 5", c); end
        checks++; if (ma !== 28'h000_0009) begin errors++; $display("FAIL conflict_mem_address: got %h want 0000009", ma); end
        checks++; if (ins !== 32'h5A5A_0090) begin errors++; $display("FAIL conflict_instr_90: got %h want 5a5a0090", ins); end
        fetch(32'h0000_0010, c, ins, ma, sm);
        checks++; if (c !== 5) begin errors++; $display("FAIL conflict_busy_10: got %0d want 5", c); end
        checks++; if (ins !== 32'h5A5A_0010) begin errors++; $display("FAIL conflict_instr_10: got %h want 5a5a0010", ins); end
    endtask

    task automatic test_flush_idle();
        int c; logic [31:0] ins; logic [27:0] ma; logic sm;
        go_idle();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        fetch(32'h0000_0010, c, ins, ma, sm);
        checks++; if (c !== 5) begin errors++; $display("FAIL flush_idle_busy: got %0d want 5", c); end
        // Flush coinciding with a hit: hit served now, block gone next cycle.
        @(posedge clk);
        #1 flush = 1'b1; address = 32'h0000_0014;
        #1;
        checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL flush_hit_busy: got %b want 0", busywait); end
        checks++; if (instruction !== 32'h5A5A_0014) begin errors++; $display("FAIL flush_hit_instr: got %h want 5a5a0014", instruction); end
        @(posedge clk);
        #1 flush = 1'b0;
        #1;
        checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL flush_after_hit_busy: got %b want 1", busywait); end
        wait_ready(c);
        checks++; if (c !== 5) begin errors++; $display("FAIL flush_refill_cycles: got %0d want 5", c); end
    endtask

    task automatic test_flush_mem_read();
        int c; logic [31:0] ins; logic [27:0] ma; logic sm;
        go_idle();
        fetch(32'h0000_0020, c, ins, ma, sm);
        checks++; if (c !== 5) begin errors++; $display("FAIL fmr_fill_20: got %0d want 5", c); end
        @(posedge clk);
        #1 address = 32'h0000_0030;
        @(posedge clk);
        #1 flush = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL fmr_in_mem_read: got %b want 1", mem_read); end
        @(posedge clk);
        #1 flush = 1'b0;
        wait_ready(c);
        checks++; if (instruction !== 32'h5A5A_0030) begin errors++; $display("FAIL fmr_instr_30: got %h want 5a5a0030", instruction); end
        fetch(32'h0000_0030, c, ins, ma, sm);
        checks++; if (c !== 0) begin errors++; $display("FAIL fmr_30_still_valid: got %0d want 0", c); end
        fetch(32'h0000_0020, c, ins, ma, sm);
        checks++; if (c !== 5) begin errors++; $display("FAIL fmr_20_invalid: got %0d want 5", c); end
        fetch(32'h0000_0010, c, ins, ma, sm);
        checks++; if (c !== 5) begin errors++; $display("FAIL fmr_10_invalid: got %0d want 5", c); end
    endtask

    task automatic test_reset_mid_miss();
        int c; logic [31:0] ins; logic [27:0] ma; logic sm;
        go_idle();
        @(posedge clk);
        #1 read = 1'b1; address = 32'h0000_0040;
        @(posedge clk);
        #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rmm_mem_read_before: got %b want 1", mem_read); end
        rst = 1'b1; read = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rmm_mem_read_after: got %b want 0", mem_read); end
        checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL rmm_busywait: got %b want 0", busywait); end
        checks++; if (mem_address !== 28'h0) begin errors++; $display("FAIL rmm_mem_address: got %h want 0", mem_address); end
        fetch(32'h0000_0040, c, ins, ma, sm);
        checks++; if (c !== 5) begin errors++; $display("FAIL rmm_refetch_busy: got %0d want 5", c); end
        checks++; if (ins !== 32'h5A5A_0040) begin errors++; $display("FAIL rmm_refetch_instr: got %h want 5a5a0040", ins); end
    endtask

    task automatic test_perf_counters();
        int c; logic [31:0] ins; logic [27:0] ma; logic sm;
        logic [31:0] exp_hits, exp_misses;
`ifdef ICACHE_PERF_CNT_EN
        exp_hits = 32'd3; exp_misses = 32'd1;
`else
        exp_hits = 32'd0; exp_misses = 32'd0;
`endif
        do_reset();
        fetch(32'h0000_0010, c, ins, ma, sm);
        fetch(32'h0000_0014, c, ins, ma, sm);
        fetch(32'h0000_0018, c, ins, ma, sm);
        go_idle();
        checks++; if (hit_count !== exp_hits) begin errors++; $display("FAIL perf_hit_count: got %0d want %0d", hit_count, exp_hits); end
        checks++; if (miss_count !== exp_misses) begin errors++; $display("FAIL perf_miss_count: got %0d want %0d", miss_count, exp_misses); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_conflict();
        test_flush_idle();
        test_flush_mem_read();
        test_reset_mid_miss();
        test_perf_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
